seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_slot_timer.sv | 42 ++++
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CODE_W     = 4;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Active-low anode pattern with only digit idx enabled
  function automatic logic [NUM_DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
    return AN_OFF & ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot prescaler. slot_end/frame_end describe the current count; in_blank and
// frame_end_nxt describe the count held next cycle so the parent's registered outputs line up.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  output logic             in_blank,
  output logic             slot_end,
  output logic             frame_end,
  output logic             frame_end_nxt
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_idx;

  always_comb begin
    last_idx      = (idx == IDX_W'(NUM_DIGITS - 1));
    slot_end      = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d         = slot_end ? '0 : cnt_q + CW'(1);
    frame_end     = slot_end && last_idx;
    in_blank      = (cnt_d < CW'(BLANK_CYC));
    // SCAN_DIV >= 2, so the index cannot advance on the cycle before a slot end
    frame_end_nxt = (cnt_d == CW'(SCAN_DIV - 1)) && last_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous shadow load.
// Optional digit flashing is enabled by defining SEG_FLASH_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned FLASH_DIV = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIGITS*CODE_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]        blank_in,
  input  logic [NUM_DIGITS-1:0]        flash_in,
  input  logic                         load,
  output logic                         load_ack,
  output logic [CODE_W-1:0]            y,
  output logic [NUM_DIGITS-1:0]        an,
  output logic                         frame_tick
);

  localparam int unsigned DW = NUM_DIGITS * CODE_W;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [NUM_DIGITS-1:0] flash_d;
  logic [NUM_DIGITS-1:0] dark_d;
  logic                  phase_d;
  logic [CODE_W-1:0]     y_q, y_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  load_ack_q, load_ack_d;
  logic                  frame_tick_q, frame_tick_d;

  logic in_blank, slot_end, frame_end, frame_end_nxt;
  logic capture;

  seg_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk           (clk),
    .rst           (rst),
    .idx           (idx_q),
    .in_blank      (in_blank),
    .slot_end      (slot_end),
    .frame_end     (frame_end),
    .frame_end_nxt (frame_end_nxt)
  );

  assign capture = frame_end && load;

`ifdef SEG_FLASH_EN
  localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q;
  logic [NUM_DIGITS-1:0] flash_q;

  // Frame counter; phase flips every FLASH_DIV frames
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    flash_d = capture ? flash_in : flash_q;
    if (frame_end) begin
      if (fcnt_q == FW'(FLASH_DIV - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      flash_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      flash_q <= flash_d;
    end
  end
`else
  logic unused_flash;

  always_comb begin
    phase_d = 1'b0;
    flash_d = '0;
  end

  assign unused_flash = (^flash_in) ^ (FLASH_DIV == 0);
`endif

  // Next-state and output decode; outputs reflect the slot position of the next cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (!in_blank) state_d = SHOW;
      SHOW:    if (slot_end)  state_d = BLANK;
      default: state_d = BLANK;
    endcase

    idx_d        = slot_end ? idx_q + IDX_W'(1) : idx_q;
    digits_d     = capture ? digits_in : digits_q;
    blank_d      = capture ? blank_in : blank_q;
    dark_d       = blank_d | (flash_d & {NUM_DIGITS{phase_d}});
    y_d          = digits_d[{idx_d, 2'b00} +: CODE_W];
    an_d         = ((state_d == SHOW) && !dark_d[idx_d]) ? an_select(idx_d) : AN_OFF;
    load_ack_d   = capture;
    frame_tick_d = frame_end_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      digits_q     <= '0;
      blank_q      <= '0;
      y_q          <= '0;
      an_q         <= AN_OFF;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      digits_q     <= digits_d;
      blank_q      <= blank_d;
      y_q          <= y_d;
      an_q         <= an_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign y          = y_q;
  assign an         = an_q;
  assign load_ack   = load_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table of load vectors plus reset and short-pulse sequences.
module tb_seg_scan_ctrl;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FLASH_DIV = 2;
  localparam int unsigned FRAME     = 4 * SCAN_DIV;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [3:0]  flash_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  y;
  logic [3:0]  an;
  logic        frame_tick;

  seg_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .FLASH_DIV (FLASH_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .flash_in   (flash_in),
    .load       (load),
    .load_ack   (load_ack),
    .y          (y),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_y / exp_an packed as {slot3, slot2, slot1, slot0}; exp_an is the lit-window value
  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      blank;
    logic [3:0]      flash;
    logic [3:0][3:0] exp_y;
    logic [3:0][3:0] exp_an;
  } vec_t;

  vec_t vecs [5];
  int   checks   = 0;
  int   failures = 0;
  int   frame_no = 0;
  int   cur_pos  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (frame %0d pos %0d, t=%0t)",
               name, act, exp, frame_no, cur_pos, $time);
    end
  endtask

  // Checks one full frame starting at its first cycle (already sampled position 0)
  task automatic check_frame(input vec_t v, input bit ack_first, input bit pulse);
    int s;
    int q;
    logic [3:0] exp_an;
    for (int p = 0; p < int'(FRAME); p++) begin
      if (p > 0) @(negedge clk);
      cur_pos = p;
      s = p / int'(SCAN_DIV);
      q = p % int'(SCAN_DIV);
      exp_an = (q < int'(BLANK_CYC)) ? 4'b1111 : v.exp_an[s];
`ifdef SEG_FLASH_EN
      if (((frame_no / int'(FLASH_DIV)) % 2) == 1 && v.flash[s]) exp_an = 4'b1111;
`endif
      chk("y", 32'(y), 32'(v.exp_y[s]));
      chk("an", 32'(an), 32'(exp_an));
      chk("load_ack", 32'(load_ack), 32'(ack_first && p == 0));
      chk("frame_tick", 32'(frame_tick), 32'(p == int'(FRAME) - 1));
      if (pulse && p == 4) begin
        load      = 1'b1;
        digits_in = 16'hDEAD;
      end
      if (pulse && p == 7) load = 1'b0;
    end
    frame_no++;
  endtask

  // Holds load with the vector's data until acked; returns at the ack cycle
  task automatic load_vec(input vec_t v);
    bit ok;
    bit prev_tick;
    ok        = 1'b0;
    prev_tick = 1'b0;
    @(negedge clk);
    digits_in = v.digits;
    blank_in  = v.blank;
    flash_in  = v.flash;
    load      = 1'b1;
    for (int i = 0; i < 2 * int'(FRAME) && !ok; i++) begin
      @(negedge clk);
      if (load_ack) begin
        ok = 1'b1;
        chk("ack_after_tick", 32'(prev_tick), 32'd1);
      end
      prev_tick = frame_tick;
      if (frame_tick) frame_no++;
    end
    load = 1'b0;
    chk("ack_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{digits: 16'h0000, blank: 4'b0000, flash: 4'b0000,
                exp_y:  {4'h0, 4'h0, 4'h0, 4'h0},
                exp_an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = '{digits: 16'h1234, blank: 4'b0000, flash: 4'b0000,
                exp_y:  {4'h1, 4'h2, 4'h3, 4'h4},
                exp_an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[2] = '{digits: 16'h1234, blank: 4'b1000, flash: 4'b0000,
                exp_y:  {4'h1, 4'h2, 4'h3, 4'h4},
                exp_an: {4'b1111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[3] = '{digits: 16'hF0A5, blank: 4'b0101, flash: 4'b0000,
                exp_y:  {4'hF, 4'h0, 4'hA, 4'h5},
                exp_an: {4'b0111, 4'b1111, 4'b1101, 4'b1111}};
    vecs[4] = '{digits: 16'h0007, blank: 4'b0000, flash: 4'b0001,
                exp_y:  {4'h0, 4'h0, 4'h0, 4'h7},
                exp_an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};

    rst       = 1'b1;
    digits_in = '0;
    blank_in  = '0;
    flash_in  = '0;
    load      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_ack", 32'(load_ack), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);

    // Reset release: 2 dark cycles then digit 0 lit, all zeros
    rst = 1'b0;
    frame_no = 0;
    #1;
    check_frame(vecs[0], 1'b0, 1'b0);

    // Table of load vectors, each checked over the frame after its ack
    for (int v = 1; v < 5; v++) begin
      load_vec(vecs[v]);
      check_frame(vecs[v], 1'b1, 1'b0);
    end

    // Flash vector stays loaded; follow three more frames
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      check_frame(vecs[4], 1'b0, 1'b0);
    end

    // Short load pulse that never sees a boundary: no capture, no ack
    @(negedge clk);
    check_frame(vecs[4], 1'b0, 1'b1);
    @(negedge clk);
    check_frame(vecs[4], 1'b0, 1'b0);

    // Reset during SHOW of digit 2 with a load pending
    @(negedge clk);
    digits_in = 16'h5555;
    load      = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_rst_an", 32'(an), 32'hB);
    rst = 1'b1;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_y", 32'(y), 32'h0);
    chk("mid_rst_ack", 32'(load_ack), 32'h0);
    repeat (2) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    frame_no = 0;
    #1;
    check_frame(vecs[0], 1'b0, 1'b0);
    @(negedge clk);
    check_frame(vecs[0], 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
